// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Registered ALU execution unit for the execute stage of the multicycle MIPS
//   datapath. It decodes aluop/funct internally. Single-cycle ops complete one
//   cycle after acceptance. Shifts (1 bit per cycle) and multiply (shift-add,
//   1 multiplier bit per cycle) run iteratively under a start/busy/done
//   handshake.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high reset
//   start    in   operation request, sampled only while busy=0
//   aluop    in   00 add, 01 sub, 10 decode funct, 11 illegal
//   funct    in   R-type function field
//   shamt    in   shift amount (SW bits)
//   a, b     in   operands (WIDTH bits); a is the shift source
//   result   out  registered result, held until the next completion
//   zero     out  result == 0
//   busy     out  iterative op in progress
//   done     out  one-cycle pulse when result is updated
//   illegal  out  registered with done; last completed op was invalid
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | accepts start; single-cycle ops complete here
// S_SHIFT | shifts acc_q one bit per cycle until cnt_q reaches 0
// S_MULT  | shift-add multiply, one multiplier bit per cycle, WIDTH cycles

module alu_exec_unit #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [SW-1:0]    shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  // One extra counter bit so the multiply count (WIDTH) fits.
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MULT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLL,
    OP_SRL,
    OP_MULT,
    OP_ILL
  } op_e;

  state_e           state_q;
  op_e              op_q;
  op_e              op_dec;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             illegal_q;

  logic [WIDTH-1:0] single_res_d;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] mult_d;
  logic             last_iter;
  logic             is_shift;

  always_comb begin
    op_dec = OP_ILL;
    case (aluop)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: op_dec = OP_ADD;
          6'b100010: op_dec = OP_SUB;
          6'b100100: op_dec = OP_AND;
          6'b100101: op_dec = OP_OR;
          6'b100110: op_dec = OP_XOR;
          6'b100111: op_dec = OP_NOR;
          6'b101010: op_dec = OP_SLT;
          6'b000000: op_dec = OP_SLL;
          6'b000010: op_dec = OP_SRL;
          6'b011000: op_dec = OP_MULT;
          default:   op_dec = OP_ILL;
        endcase
      end
      default: op_dec = OP_ILL;
    endcase
  end

  // Result for ops that finish in S_IDLE. Shifts only get here with shamt=0,
  // where the result is the unshifted source. Illegal ops yield 0.
  always_comb begin
    single_res_d = '0;
    case (op_dec)
      OP_ADD:         single_res_d = a + b;
      OP_SUB:         single_res_d = a - b;
      OP_AND:         single_res_d = a & b;
      OP_OR:          single_res_d = a | b;
      OP_XOR:         single_res_d = a ^ b;
      OP_NOR:         single_res_d = ~(a | b);
      OP_SLT:         single_res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL, OP_SRL: single_res_d = a;
      default:        single_res_d = '0;
    endcase
  end

  assign shift_d   = (op_q == OP_SLL) ? (acc_q << 1) : (acc_q >> 1);
  assign mult_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = (cnt_q == CW'(1));
  assign is_shift  = (op_dec == OP_SLL) || (op_dec == OP_SRL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      result_q  <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q <= op_dec;
            if (is_shift && (shamt != '0)) begin
              acc_q   <= a;
              cnt_q   <= CW'(shamt);
              state_q <= S_SHIFT;
            end else if (op_dec == OP_MULT) begin
              acc_q    <= '0;
              mcand_q  <= a;
              mplier_q <= b;
              cnt_q    <= CW'(WIDTH);
              state_q  <= S_MULT;
            end else begin
              result_q  <= single_res_d;
              illegal_q <= (op_dec == OP_ILL);
              done_q    <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          acc_q <= shift_d;
          cnt_q <= cnt_q - CW'(1);
          if (last_iter) begin
            result_q  <= shift_d;
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end
        end

        S_MULT: begin
          // Partial product accumulates in acc_q; multiplicand walks left,
          // multiplier walks right so bit 0 is always the current bit.
          acc_q    <= mult_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (last_iter) begin
            result_q  <= mult_d;
            illegal_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result  = result_q;
  assign zero    = (result_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule
